// File: rtl/aes_key_scheduler_pkg.sv
// Shared AES definitions: key types, round counts, Rcon, key-schedule FSM
// encoding and the forward S-box (also used by the SubBytes stage).
// Pure declarations; no logic of its own.
package AESDefinitions;

  typedef logic [127:0] key_t;
  typedef logic [127:0] roundKey_t;

  localparam logic [3:0] NUM_ROUNDS     = 4'd10;
  localparam int         NUM_ROUND_KEYS = 11;

  // Entry 0 is never used: round keys 1..10 take Rcon[1..10].
  localparam logic [7:0] RCON [NUM_ROUND_KEYS] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } keySchedState_t;

  // Forward S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte b sits at bit offset (255-b)*8; ~b == 255-b for an 8-bit value.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx  = {~b, 3'b000};
    sbox = SBOX_TABLE[idx +: 8];
  endfunction

endpackage

// File: rtl/aes_key_scheduler_if.sv
// Key handshake and round-key result bundle between key source, scheduler
// and cipher datapath. slave = scheduler side, master = key source side.
// No logic inside.
import AESDefinitions::*;

interface aes_key_scheduler_if;
  logic      key_valid;
  key_t      key;
  logic      key_ready;
  roundKey_t round_keys [NUM_ROUND_KEYS];
  logic      keys_valid;
  logic      busy;

  modport slave (
    input  key_valid, key,
    output key_ready, round_keys, keys_valid, busy
  );

  modport master (
    output key_valid, key,
    input  key_ready, round_keys, keys_valid, busy
  );
endinterface

// File: rtl/aes_key_scheduler_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
// Latency: combinational.
// No handshake.
import AESDefinitions::*;

module aes_sub_word (
  input  logic [31:0] word,
  output logic [31:0] subbed
);
  assign subbed = {sbox(word[31:24]), sbox(word[23:16]),
                   sbox(word[15:8]),  sbox(word[7:0])};
endmodule

// File: rtl/aes_key_scheduler.sv
// Iterative AES-128 key expansion: one round key per clock into an 11-entry file.
// Latency: accept at edge N -> rk[k] after edge N+k, keys_valid after edge N+10.
// Backpressure: key_ready low during EXPAND; key_valid ignored until IDLE/DONE.
import AESDefinitions::*;

module aes_key_scheduler (
  input logic            clock,
  input logic            reset,
  aes_key_scheduler_if.slave kif
);

  keySchedState_t state, state_nxt;
  logic [3:0]     rnd;
  key_t           w_q;
  roundKey_t      rk_q [NUM_ROUND_KEYS];

  logic        rdy, done, running, accept;
  logic [31:0] sub_out, t, n0, n1, n2, n3;

  assign accept = rdy && kif.key_valid;

  // RotWord of the last word feeds SubWord.
  aes_sub_word u_sub_word (
    .word   ({w_q[23:0], w_q[31:24]}),
    .subbed (sub_out)
  );

  assign t  = sub_out ^ {RCON[rnd], 24'h0};
  assign n0 = w_q[127:96] ^ t;
  assign n1 = n0 ^ w_q[95:64];
  assign n2 = n1 ^ w_q[63:32];
  assign n3 = n2 ^ w_q[31:0];

  // State register; reset aborts any expansion in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake/status decode.
  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    done      = 1'b0;
    running   = 1'b0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (kif.key_valid) state_nxt = EXPAND;
      end
      EXPAND: begin
        running = 1'b1;
        if (rnd == NUM_ROUNDS) state_nxt = DONE;
      end
      DONE: begin
        rdy  = 1'b1;
        done = 1'b1;
        if (kif.key_valid) state_nxt = EXPAND;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Working word register, round counter and round-key file.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rnd <= 4'd0;
      w_q <= '0;
      for (int i = 0; i < NUM_ROUND_KEYS; i++) rk_q[i] <= '0;
    end else if (accept) begin
      rk_q[0] <= kif.key;
      w_q     <= kif.key;
      rnd     <= 4'd1;
    end else if (state == EXPAND) begin
      rk_q[rnd] <= {n0, n1, n2, n3};
      w_q       <= {n0, n1, n2, n3};
      rnd       <= rnd + 4'd1;
    end
  end

  assign kif.key_ready  = rdy;
  assign kif.keys_valid = done;
  assign kif.busy       = running;
  assign kif.round_keys = rk_q;

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Self-checking bench for aes_key_scheduler against a FIPS-197 style model
// (S-box derived from GF(2^8) inversion + affine map, word-wise expansion).
// Random keys plus the directed scenarios: FIPS vectors, ignore, back-to-back, reset, hold.
import AESDefinitions::*;

module tb_aes_key_scheduler;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  aes_key_scheduler_if kif ();

  aes_key_scheduler dut (
    .clock (clock),
    .reset (reset),
    .kif   (kif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]   ref_sbox [256];
  logic [127:0] exp_rk   [11];

  localparam logic [127:0] A1_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_RK1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic void build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      b   = 8'(x);
      inv = 8'h01;
      if (b == 8'h00) inv = 8'h00;
      else for (int e = 0; e < 254; e++) inv = gmul(inv, b);
      ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic void expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {ref_sbox[tmp[31:24]], ref_sbox[tmp[23:16]], ref_sbox[tmp[15:8]], ref_sbox[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offer a key on the negedge; returns #1 after the accepting edge.
  task automatic start_key(input logic [127:0] k);
    @(negedge clock);
    chk("ready_before_accept", kif.key_ready, 1'b1);
    kif.key_valid = 1'b1;
    kif.key       = k;
    @(posedge clock);
    #1;
    kif.key_valid = 1'b0;
    kif.key       = rand_key();
  endtask

  // Counts edges until keys_valid; bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (kif.keys_valid !== 1'b1 && lat < 30) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic check_keys(input logic [127:0] k, input string tag);
    expand(k);
    for (int i = 0; i < 11; i++) chk($sformatf("%s_rk%0d", tag, i), kif.round_keys[i], exp_rk[i]);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_key_ready"}, kif.key_ready, 1'b1);
    chk({tag, "_keys_valid"}, kif.keys_valid, 1'b0);
    chk({tag, "_busy"}, kif.busy, 1'b0);
    for (int i = 0; i < 11; i++) chk($sformatf("%s_rk%0d_zero", tag, i), kif.round_keys[i], 128'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    logic [127:0] k, k2;

    build_sbox();
    kif.key_valid = 1'b0;
    kif.key       = '0;
    reset         = 1'b0;
    #12;
    check_reset_vals("reset");
    @(negedge clock);
    reset = 1'b1;

    // FIPS-197 A.1
    start_key(A1_KEY);
    chk("a1_busy", kif.busy, 1'b1);
    chk("a1_rk0", kif.round_keys[0], A1_KEY);
    wait_done(lat);
    chk("a1_latency", 128'(lat), 128'd10);
    chk("a1_rk1", kif.round_keys[1], A1_RK1);
    chk("a1_rk10", kif.round_keys[10], A1_RK10);
    chk("a1_busy_done", kif.busy, 1'b0);
    check_keys(A1_KEY, "a1");

    // All-zero key, accepted back-to-back from DONE
    start_key(128'h0);
    chk("b2b_keys_valid_drop", kif.keys_valid, 1'b0);
    chk("b2b_rk0", kif.round_keys[0], 128'h0);
    wait_done(lat);
    chk("zero_latency", 128'(lat), 128'd10);
    chk("zero_rk1", kif.round_keys[1], Z_RK1);
    chk("zero_rk10", kif.round_keys[10], Z_RK10);

    // Key offered during EXPAND is ignored
    start_key(A1_KEY);
    k2 = rand_key();
    repeat (3) begin
      @(negedge clock);
      chk("expand_not_ready", kif.key_ready, 1'b0);
      kif.key_valid = 1'b1;
      kif.key       = k2;
    end
    @(negedge clock);
    kif.key_valid = 1'b0;
    wait_done(lat);
    chk("ignore_done", kif.keys_valid, 1'b1);
    check_keys(A1_KEY, "ignore");

    // Hold idle in DONE for 50 cycles
    repeat (50) begin
      @(posedge clock);
      #1;
      chk("hold_keys_valid", kif.keys_valid, 1'b1);
    end
    check_keys(A1_KEY, "hold");

    // Asynchronous reset at rnd=5
    start_key(rand_key());
    repeat (4) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("midreset");
    @(negedge clock);
    reset = 1'b1;
    start_key(A1_KEY);
    wait_done(lat);
    chk("post_reset_latency", 128'(lat), 128'd10);
    chk("post_reset_rk10", kif.round_keys[10], A1_RK10);
    check_keys(A1_KEY, "post_reset");

    // Random keys with random gaps
    for (int n = 0; n < 8; n++) begin
      k = rand_key();
      repeat ($urandom_range(0, 3)) @(posedge clock);
      start_key(k);
      chk("rand_rk0", kif.round_keys[0], k);
      wait_done(lat);
      chk("rand_latency", 128'(lat), 128'd10);
      check_keys(k, $sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
